// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives two passes through an external N-bit
// adder (raw add/sub, then conditional correction by the modulus).
module mod_addsub_ctrl #(
  parameter int N = 384
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] modulus,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_sub,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N:0]   add_result,
  input  logic         add_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OP1_GO   = 3'd1,
    OP1_WAIT = 3'd2,
    OP2_GO   = 3'd3,
    OP2_WAIT = 3'd4
  } state_e;

  typedef struct packed {
    logic         sub;
    logic [N-1:0] modulus;
  } req_t;

  state_e       state_q;
  req_t         req_q;
  logic [N:0]   s_q;
  logic         use_r;
  logic [N-1:0] red;

  // Add: take s-p unless it borrowed with no carry out of s (i.e. s < p).
  // Sub: only a borrow in s calls for the s+p correction.
  always_comb begin
    use_r = req_q.sub ? s_q[N] : (s_q[N] | ~add_result[N]);
    red   = use_r ? add_result[N-1:0] : s_q[N-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      s_q       <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      add_start <= 1'b0;
      add_sub   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      done      <= 1'b0;
      add_start <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            req_q.sub     <= subtract;
            req_q.modulus <= modulus;
            add_a         <= in_a;
            add_b         <= in_b;
            add_sub       <= subtract;
            add_start     <= 1'b1;
            busy          <= 1'b1;
            state_q       <= OP1_GO;
          end
        end
        OP1_GO: state_q <= OP1_WAIT;
        OP1_WAIT: begin
          if (add_done) begin
            s_q       <= add_result;
            add_a     <= add_result[N-1:0];
            add_b     <= req_q.modulus;
            add_sub   <= ~req_q.sub;
            add_start <= 1'b1;
            state_q   <= OP2_GO;
          end
        end
        OP2_GO: state_q <= OP2_WAIT;
        OP2_WAIT: begin
          if (add_done) begin
            result  <= red;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
